multicycle_adder: RTL
=====================

Name: multicycle_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock.
- The carry is held in a register between slices, so WIDTH is not limited by single-cycle ripple depth.
- Valid/ready handshake on both input and output. Shared arithmetic unit for datapaths wider than one cycle can ripple.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥1.
- CHUNK, 4, bits processed per cycle. 1 ≤ CHUNK ≤ WIDTH, and WIDTH % CHUNK == 0 (elaboration-time assertion).
- NCHUNK, WIDTH/CHUNK, derived localparam: compute cycles per operation.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used for add only.
- sub  input  1  0 = a+b+cin; 1 = a−b (a + ~b + 1, cin ignored).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB. For sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n). The assertion of rst_n=0 immediately forces:
  - state IDLE
  - out_valid=0
  - sum=0, cout=0, ovf=0
  - slice counter=0, carry register=0
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge t0, latch a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin. Clear counter. Go to CALC.
  - CALC: in_ready=0. Each edge adds slice idx {a_l[idx], b_eff[idx], carry}, writes CHUNK sum bits into sum[idx*CHUNK +: CHUNK] and the slice carry-out into the carry register, then increments idx.
  - CALC, last slice (idx==NCHUNK−1): same edge also writes cout = final carry and ovf = (a_l[MSB]==b_eff[MSB]) && (sum[MSB]!=a_l[MSB]). Go to DONE.
  - DONE: out_valid=1 and in_ready=0. sum/cout/ovf are stable. When out_ready=1 at an edge, out_valid→0 and go to IDLE.
- Latency and throughput:
  - out_valid rises after edge t0+NCHUNK, i.e. NCHUNK cycles after acceptance.
  - Minimum initiation interval is NCHUNK+2 cycles (accept, NCHUNK compute, DONE handshake, return to IDLE).
- Handshake and output rules:
  - No new accept while in CALC or DONE. in_ready is driven from state only, with no combinational path from out_ready.
  - a/b/cin/sub changes after acceptance have no effect.
  - sum bits are partially updated during CALC. They are meaningful only while out_valid=1.
  - After the DONE handshake, sum/cout/ovf keep their last values until the next operation writes them.
- Boundary conditions:
  - CHUNK==WIDTH: single compute cycle, result one cycle after accept.
  - out_ready held high in DONE: completes in the first DONE cycle.
  - out_ready asserted before out_valid: no effect.
  - rst_n asserted mid-CALC or in DONE: operation discarded, and the block is in IDLE with zeroed outputs on deassert.
  - Full-scale wrap: all ones + 1 produces sum=0, cout=1.

Test Plan:
- WIDTH=16, CHUNK=4, add: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. out_valid high exactly 4 cycles after the accept edge.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x0FED, cin=1 → sum=0x2222, cout=0, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) → sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → sum/cout/ovf/out_valid unchanged, in_ready=0 and in_valid ignored. out_ready=1 → in_ready=1 the next cycle.
- Reset mid-operation: pull rst_n low during the 2nd CALC cycle → out_valid=0, sum=0, in_ready=1 immediately, before any clock edge. A fresh 0x0001+0x0001 then yields 0x0002.
- Parameter sweep: CHUNK ∈ {1,4,16} with WIDTH=16 and CHUNK=8 with WIDTH=32, 1000 random ops each against a reference model. Check latency = NCHUNK cycles and that in_ready is never high outside IDLE.

Source files
------------

// File: rtl/multicycle_adder.sv
// ---------------------------------------------------------------------------
// multicycle_adder
//   Multi-cycle adder/subtractor. WIDTH-bit operands are added CHUNK bits per
//   clock, and the carry is held in a register between slices. Operands are
//   accepted with a valid/ready handshake and the result is presented with a
//   second valid/ready handshake.
//
// Ports
//   clk       : single clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands present
//   in_ready  : block can accept operands (high only in IDLE)
//   a, b      : WIDTH-bit operands
//   cin       : carry-in, add only
//   sub       : 0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored)
//   out_valid : result available
//   out_ready : consumer takes result
//   sum       : WIDTH-bit result
//   cout      : carry-out of MSB (for sub, 1 = no borrow)
//   ovf       : signed two's-complement overflow
// ---------------------------------------------------------------------------
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject parameter combinations that would leave a partial slice.
  if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("multicycle_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] beff_q, beff_d;      // b, or ~b for subtract
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [31:0]      shift_s;
  logic [CHUNK-1:0] a_slice_s;
  logic [CHUNK-1:0] b_slice_s;
  logic [CHUNK:0]   slice_res_s;
  logic [WIDTH-1:0] sum_merge_s;

  // Slice adder: select the current CHUNK of each operand, add with the
  // registered carry, and merge the slice result into the running sum.
  always_comb begin
    shift_s     = 32'(idx_q) * 32'(CHUNK);
    a_slice_s   = CHUNK'(a_q >> shift_s);
    b_slice_s   = CHUNK'(beff_q >> shift_s);
    slice_res_s = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_q};
    sum_merge_s = (sum_q & ~(SLICE_MASK << shift_s))
                | (WIDTH'(slice_res_s[CHUNK-1:0]) << shift_s);
  end

  // Next-state and next-output computation for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    beff_d  = beff_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = ST_CALC;
          a_d     = a;
          beff_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        sum_d   = sum_merge_s;
        carry_d = slice_res_s[CHUNK];
        if (idx_q == LAST_IDX) begin
          // Overflow: operands share a sign that the result does not.
          cout_d  = slice_res_s[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (sum_merge_s[WIDTH-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Handshake outputs are registered decodes of the next state, so
    // in_ready has no combinational path from out_ready.
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      beff_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      beff_q      <= beff_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
